// File: rtl/dram_sched_pkg.sv
// dram_sched_pkg: shared command encoding, widths and helpers for the DDR2 command scheduler
package dram_sched_pkg;
    localparam int DRAM_RA_WIDTH  = 14;
    localparam int DRAM_CA_WIDTH  = 11;
    localparam int AXI_ID_WIDTH   = 4;
    localparam int T_WIDTH        = 4;
    localparam int DFI_ADDR_WIDTH = 14;
    localparam int DFI_BA_WIDTH   = 3;
    localparam int DFI_CS_WIDTH   = 1;
    localparam int A10_BIT        = 10;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_PRE,
        CMD_REF
    } cmd_t;

    function automatic logic [2:0] cmd_rcw(input cmd_t c);
        return c == CMD_ACT ? 3'b011 :
               c == CMD_RD  ? 3'b101 :
               c == CMD_WR  ? 3'b100 :
               c == CMD_PRE ? 3'b010 :
               c == CMD_REF ? 3'b001 : 3'b111;
    endfunction

    function automatic logic [T_WIDTH-1:0] sat_dec(input logic [T_WIDTH-1:0] x);
        return x == '0 ? '0 : x - T_WIDTH'(1);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant starting the search at ptr
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;
    logic          found;

    // Walk banks from ptr upwards (wrapping) and grant the first requester
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dram_cmd_sched.sv
// dram_cmd_sched: rank-level DDR2 command scheduler with inter-bank timing and DFI data-enable windows
module dram_cmd_sched
    import dram_sched_pkg::*;
#(
    parameter int NUM_BANKS    = 4,
    parameter int BURST_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic [NUM_BANKS-1:0]               act_req,
    input  logic [NUM_BANKS-1:0]               rd_req,
    input  logic [NUM_BANKS-1:0]               wr_req,
    input  logic [NUM_BANKS-1:0]               pre_req,
    input  logic [NUM_BANKS-1:0]               ref_req,
    input  logic [NUM_BANKS*DRAM_RA_WIDTH-1:0] ra,
    input  logic [NUM_BANKS*DRAM_CA_WIDTH-1:0] ca,
    input  logic [NUM_BANKS*AXI_ID_WIDTH-1:0]  id,
    output logic [NUM_BANKS-1:0]               act_gnt,
    output logic [NUM_BANKS-1:0]               rd_gnt,
    output logic [NUM_BANKS-1:0]               wr_gnt,
    output logic [NUM_BANKS-1:0]               pre_gnt,
    output logic [NUM_BANKS-1:0]               ref_gnt,
    input  logic [T_WIDTH-1:0]                 t_rrd_m1,
    input  logic [T_WIDTH-1:0]                 t_ccd_m1,
    input  logic [T_WIDTH-1:0]                 t_wtr_m1,
    input  logic [T_WIDTH-1:0]                 t_rtw_m1,
    input  logic [3:0]                         dfi_wren_lat,
    input  logic [3:0]                         dfi_rden_lat,
    output logic                               dfi_cke,
    output logic [DFI_CS_WIDTH-1:0]            dfi_cs_n,
    output logic                               dfi_ras_n,
    output logic                               dfi_cas_n,
    output logic                               dfi_we_n,
    output logic [DFI_BA_WIDTH-1:0]            dfi_ba,
    output logic [DFI_ADDR_WIDTH-1:0]          dfi_addr,
    output logic                               dfi_odt,
    output logic                               dfi_wrdata_en,
    output logic                               dfi_rddata_en,
    output logic [AXI_ID_WIDTH-1:0]            cas_id
);
    localparam int BW       = $clog2(NUM_BANKS);
    localparam int SR_DEPTH = 16 + BURST_CYCLES;
    localparam logic [SR_DEPTH-1:0] BURST_MASK = SR_DEPTH'((1 << BURST_CYCLES) - 1);

    logic [T_WIDTH-1:0]        rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
    logic [BW-1:0]             cas_ptr, act_ptr, pre_ptr, bank, nxt;
    logic [NUM_BANKS-1:0]      rd_ok, wr_ok, act_ok, pre_ok;
    logic [NUM_BANKS-1:0]      cas_arb, act_arb, pre_arb, gnt_any;
    logic                      sel_ref, sel_cas, sel_act, sel_pre;
    cmd_t                      cmd;
    logic [DRAM_RA_WIDTH-1:0]  ra_sel;
    logic [DRAM_CA_WIDTH-1:0]  ca_sel;
    logic [AXI_ID_WIDTH-1:0]   id_sel;
    logic [DFI_ADDR_WIDTH-1:0] ca_addr;
    logic [SR_DEPTH-1:0]       wr_sr, rd_sr;

    assign rd_ok  = rd_req  & {NUM_BANKS{en && ccd_cnt == '0 && wtr_cnt == '0}};
    assign wr_ok  = wr_req  & {NUM_BANKS{en && ccd_cnt == '0 && rtw_cnt == '0}};
    assign act_ok = act_req & {NUM_BANKS{en && rrd_cnt == '0}};
    assign pre_ok = pre_req & {NUM_BANKS{en}};

    rr_arbiter #(.N(NUM_BANKS)) u_cas_arb (.req(rd_ok | wr_ok), .ptr(cas_ptr), .gnt(cas_arb));
    rr_arbiter #(.N(NUM_BANKS)) u_act_arb (.req(act_ok),        .ptr(act_ptr), .gnt(act_arb));
    rr_arbiter #(.N(NUM_BANKS)) u_pre_arb (.req(pre_ok),        .ptr(pre_ptr), .gnt(pre_arb));

    assign sel_ref = en && &ref_req;
    assign sel_cas = !sel_ref && |(rd_ok | wr_ok);
    assign sel_act = !sel_ref && !sel_cas && |act_ok;
    assign sel_pre = !sel_ref && !sel_cas && !sel_act && |pre_ok;

    assign ref_gnt = {NUM_BANKS{sel_ref}};
    assign rd_gnt  = sel_cas ? cas_arb & rd_ok : '0;
    assign wr_gnt  = sel_cas ? cas_arb & wr_ok & ~rd_ok : '0;
    assign act_gnt = sel_act ? act_arb : '0;
    assign pre_gnt = sel_pre ? pre_arb : '0;
    assign gnt_any = rd_gnt | wr_gnt | act_gnt | pre_gnt;

    // Binary index of the bank that won this cycle (0 for REF or idle)
    always_comb begin
        bank = '0;
        for (int i = 0; i < NUM_BANKS; i++)
            if (gnt_any[i]) bank = BW'(i);
    end

    assign nxt = (int'(bank) == NUM_BANKS - 1) ? '0 : bank + BW'(1);
    assign cmd = sel_ref ? CMD_REF : |rd_gnt ? CMD_RD : |wr_gnt ? CMD_WR :
                 sel_act ? CMD_ACT : sel_pre ? CMD_PRE : CMD_NOP;

    assign ra_sel  = ra[int'(bank)*DRAM_RA_WIDTH +: DRAM_RA_WIDTH];
    assign ca_sel  = ca[int'(bank)*DRAM_CA_WIDTH +: DRAM_CA_WIDTH];
    assign id_sel  = id[int'(bank)*AXI_ID_WIDTH +: AXI_ID_WIDTH];
    assign ca_addr = DFI_ADDR_WIDTH'(ca_sel) & ~(DFI_ADDR_WIDTH'(1) << A10_BIT);
    assign dfi_odt = 1'b0;

    // Register the granted command onto the DFI control pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dfi_cke                          <= 1'b0;
            dfi_cs_n                         <= '1;
            {dfi_ras_n, dfi_cas_n, dfi_we_n} <= 3'b111;
            dfi_ba                           <= '0;
            dfi_addr                         <= '0;
            cas_id                           <= '0;
        end else begin
            dfi_cke                          <= en;
            dfi_cs_n                         <= cmd == CMD_NOP ? '1 : '0;
            {dfi_ras_n, dfi_cas_n, dfi_we_n} <= cmd_rcw(cmd);
            dfi_ba                           <= DFI_BA_WIDTH'(bank);
            dfi_addr                         <= sel_act ? DFI_ADDR_WIDTH'(ra_sel) : sel_cas ? ca_addr : '0;
            cas_id                           <= sel_cas ? id_sel : cas_id;
        end
    end

    // Timing counters load on a grant and saturate at zero; pointers move past the winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt} <= '0;
            {cas_ptr, act_ptr, pre_ptr}          <= '0;
        end else begin
            rrd_cnt <= sel_act ? t_rrd_m1 : sat_dec(rrd_cnt);
            ccd_cnt <= sel_cas ? t_ccd_m1 : sat_dec(ccd_cnt);
            wtr_cnt <= |wr_gnt ? t_wtr_m1 : sat_dec(wtr_cnt);
            rtw_cnt <= |rd_gnt ? t_rtw_m1 : sat_dec(rtw_cnt);
            cas_ptr <= sel_cas ? nxt : cas_ptr;
            act_ptr <= sel_act ? nxt : act_ptr;
            pre_ptr <= sel_pre ? nxt : pre_ptr;
        end
    end

    // Data-enable windows: bit k of the shifter is the enable k cycles after the command cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sr <= '0;
            rd_sr <= '0;
        end else begin
            wr_sr <= (wr_sr >> 1) | (|wr_gnt ? BURST_MASK << dfi_wren_lat : '0);
            rd_sr <= (rd_sr >> 1) | (|rd_gnt ? BURST_MASK << dfi_rden_lat : '0);
        end
    end

    assign dfi_wrdata_en = wr_sr[0];
    assign dfi_rddata_en = rd_sr[0];
endmodule

// File: tb/tb_dram_cmd_sched.sv
// tb_dram_cmd_sched: directed and randomized checks of the DDR2 command scheduler
module tb_dram_cmd_sched;
    import dram_sched_pkg::*;

    localparam int NB = 4;
    localparam int B  = 2;
    localparam int RA = DRAM_RA_WIDTH;
    localparam int CA = DRAM_CA_WIDTH;
    localparam int IW = AXI_ID_WIDTH;
    localparam int TW = T_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic [NB-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
    logic [NB-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic [NB*RA-1:0] ra;
    logic [NB*CA-1:0] ca;
    logic [NB*IW-1:0] id;
    logic [TW-1:0] t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
    logic [3:0] dfi_wren_lat, dfi_rden_lat;
    logic dfi_cke, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt, dfi_wrdata_en, dfi_rddata_en;
    logic [DFI_CS_WIDTH-1:0] dfi_cs_n;
    logic [DFI_BA_WIDTH-1:0] dfi_ba;
    logic [DFI_ADDR_WIDTH-1:0] dfi_addr;
    logic [IW-1:0] cas_id;

    int vectors = 0;
    int miscompares = 0;

    dram_cmd_sched #(.NUM_BANKS(NB), .BURST_CYCLES(B)) dut (
        .clk(clk), .rst(rst), .en(en),
        .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
        .ra(ra), .ca(ca), .id(id),
        .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
        .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1),
        .dfi_wren_lat(dfi_wren_lat), .dfi_rden_lat(dfi_rden_lat),
        .dfi_cke(dfi_cke), .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n),
        .dfi_we_n(dfi_we_n), .dfi_ba(dfi_ba), .dfi_addr(dfi_addr), .dfi_odt(dfi_odt),
        .dfi_wrdata_en(dfi_wrdata_en), .dfi_rddata_en(dfi_rddata_en), .cas_id(cas_id)
    );

    always #5 clk = ~clk;

    // Reference model: readiness as absolute cycle numbers, enables as a per-cycle expectation map
    int cyc = 0;
    int rdy_act, rdy_cas, rdy_rd, rdy_wr;
    int p_cas, p_act, p_pre;
    bit exp_wr [0:4095];
    bit exp_rd [0:4095];
    logic [NB-1:0] m_act, m_rd, m_wr, m_pre, m_ref;
    logic e_cke, e_cs;
    logic [2:0] e_rcw;
    int e_ba, e_addr, e_id;

    function automatic int rr(input int ptr, input logic [NB-1:0] v);
        for (int k = 0; k < NB; k++)
            if (v[(ptr + k) % NB]) return (ptr + k) % NB;
        return 0;
    endfunction

    task automatic model_reset();
        rdy_act = cyc; rdy_cas = cyc; rdy_rd = cyc; rdy_wr = cyc;
        p_cas = 0; p_act = 0; p_pre = 0;
        for (int c = cyc; c < 4096; c++) begin
            exp_wr[c] = 1'b0;
            exp_rd[c] = 1'b0;
        end
        e_cke = 1'b0; e_cs = 1'b1; e_rcw = 3'b111; e_ba = 0; e_addr = 0; e_id = 0;
    endtask

    task automatic model_eval();
        logic [NB-1:0] rd_ok, wr_ok, act_ok;
        int b;
        m_act = '0; m_rd = '0; m_wr = '0; m_pre = '0; m_ref = '0;
        rd_ok  = (en && cyc >= rdy_cas && cyc >= rdy_rd) ? rd_req : '0;
        wr_ok  = (en && cyc >= rdy_cas && cyc >= rdy_wr) ? wr_req : '0;
        act_ok = (en && cyc >= rdy_act) ? act_req : '0;
        if (en && ref_req == '1) m_ref = '1;
        else if ((rd_ok | wr_ok) != '0) begin
            b = rr(p_cas, rd_ok | wr_ok);
            if (rd_ok[b]) m_rd[b] = 1'b1;
            else m_wr[b] = 1'b1;
        end else if (act_ok != '0) m_act[rr(p_act, act_ok)] = 1'b1;
        else if (en && pre_req != '0) m_pre[rr(p_pre, pre_req)] = 1'b1;
    endtask

    task automatic model_commit();
        logic [NB-1:0] g;
        int b;
        if (rst) begin
            cyc++;
            model_reset();
            return;
        end
        g = m_act | m_rd | m_wr | m_pre;
        b = 0;
        for (int k = 0; k < NB; k++) if (g[k]) b = k;
        e_cke = en; e_cs = 1'b1; e_rcw = 3'b111; e_ba = 0; e_addr = 0;
        if (m_ref != '0) begin
            e_cs = 1'b0; e_rcw = 3'b001;
        end else if (m_act != '0) begin
            e_cs = 1'b0; e_rcw = 3'b011; e_ba = b; e_addr = int'(ra[b*RA +: RA]);
            rdy_act = cyc + int'(t_rrd_m1) + 1;
            p_act = (b + 1) % NB;
        end else if ((m_rd | m_wr) != '0) begin
            e_cs = 1'b0; e_ba = b; e_id = int'(id[b*IW +: IW]);
            e_addr = int'(ca[b*CA +: CA]) & ~(1 << 10);
            rdy_cas = cyc + int'(t_ccd_m1) + 1;
            p_cas = (b + 1) % NB;
            if (m_rd != '0) begin
                e_rcw = 3'b101;
                rdy_wr = cyc + int'(t_rtw_m1) + 1;
                for (int k = 0; k < B; k++) exp_rd[cyc + 1 + int'(dfi_rden_lat) + k] = 1'b1;
            end else begin
                e_rcw = 3'b100;
                rdy_rd = cyc + int'(t_wtr_m1) + 1;
                for (int k = 0; k < B; k++) exp_wr[cyc + 1 + int'(dfi_wren_lat) + k] = 1'b1;
            end
        end else if (m_pre != '0) begin
            e_cs = 1'b0; e_rcw = 3'b010; e_ba = b;
            p_pre = (b + 1) % NB;
        end
        cyc++;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        model_eval();
        model_commit();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        en = 1'b0;
        act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
        ra = '0; ca = '0; id = '0;
        t_rrd_m1 = '0; t_ccd_m1 = '0; t_wtr_m1 = '0; t_rtw_m1 = '0;
        dfi_wren_lat = '0; dfi_rden_lat = '0;
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        en = 1'b1; act_req = '1; rd_req = '1;
        rst = 1'b1;
        model_reset();
        tick();
        vectors++; if (dfi_cke !== 1'b0) begin miscompares++; $display("FAIL reset_cke: got %b expected 0", dfi_cke); end
        vectors++; if (dfi_cs_n !== '1) begin miscompares++; $display("FAIL reset_cs_n: got %b expected all-ones", dfi_cs_n); end
        vectors++; if ({dfi_ras_n, dfi_cas_n, dfi_we_n} !== 3'b111) begin miscompares++; $display("FAIL reset_rcw: got %b expected 111", {dfi_ras_n, dfi_cas_n, dfi_we_n}); end
        vectors++; if (dfi_ba !== '0 || dfi_addr !== '0) begin miscompares++; $display("FAIL reset_ba_addr: got ba=%0d addr=%h expected 0/0", dfi_ba, dfi_addr); end
        vectors++; if ({dfi_odt, dfi_wrdata_en, dfi_rddata_en} !== 3'b000) begin miscompares++; $display("FAIL reset_odt_en: got %b expected 000", {dfi_odt, dfi_wrdata_en, dfi_rddata_en}); end
        vectors++; if (cas_id !== '0) begin miscompares++; $display("FAIL reset_cas_id: got %h expected 0", cas_id); end
        rst = 1'b0;
    endtask

    task automatic test_act();
        do_reset();
        en = 1'b1;
        act_req = 4'b0100;
        ra[2*RA +: RA] = 14'h1A5;
        settle();
        vectors++; if (act_gnt !== 4'b0100 || (rd_gnt | wr_gnt | pre_gnt | ref_gnt) !== '0) begin miscompares++; $display("FAIL act_gnt: got act=%b other=%b expected act=0100 other=0000", act_gnt, rd_gnt | wr_gnt | pre_gnt | ref_gnt); end
        tick();
        act_req = '0;
        vectors++; if (dfi_cs_n !== '0 || {dfi_ras_n, dfi_cas_n, dfi_we_n} !== 3'b011) begin miscompares++; $display("FAIL act_cmd: got cs_n=%b rcw=%b expected 0/011", dfi_cs_n, {dfi_ras_n, dfi_cas_n, dfi_we_n}); end
        vectors++; if (dfi_ba !== 3'd2 || dfi_addr !== 14'h1A5) begin miscompares++; $display("FAIL act_addr: got ba=%0d addr=%h expected 2/1a5", dfi_ba, dfi_addr); end
        vectors++; if (dfi_cke !== 1'b1) begin miscompares++; $display("FAIL act_cke: got %b expected 1", dfi_cke); end
    endtask

    task automatic test_rrd();
        logic [NB-1:0] e;
        do_reset();
        en = 1'b1;
        t_rrd_m1 = 4'd2;
        act_req = '1;
        for (int k = 0; k < 12; k++) begin
            settle();
            e = (k % 3 == 0) ? NB'(1) << (k / 3) : '0;
            vectors++; if (act_gnt !== e) begin miscompares++; $display("FAIL rrd_spacing[%0d]: got %b expected %b", k, act_gnt, e); end
            tick();
            act_req = act_req & ~e;
        end
    endtask

    task automatic test_wtr();
        logic [NB-1:0] er, ea;
        do_reset();
        en = 1'b1;
        t_wtr_m1 = 4'd5;
        t_ccd_m1 = 4'd1;
        wr_req = 4'b0010;
        settle();
        vectors++; if (wr_gnt !== 4'b0010) begin miscompares++; $display("FAIL wtr_wr_gnt: got %b expected 0010", wr_gnt); end
        tick();
        wr_req = '0; rd_req = 4'b0010; act_req = 4'b1000;
        for (int k = 1; k <= 6; k++) begin
            settle();
            er = (k == 6) ? 4'b0010 : 4'b0000;
            ea = (k == 1) ? 4'b1000 : 4'b0000;
            vectors++; if (rd_gnt !== er || act_gnt !== ea) begin miscompares++; $display("FAIL wtr_gap[%0d]: got rd=%b act=%b expected rd=%b act=%b", k, rd_gnt, act_gnt, er, ea); end
            tick();
            if (k == 1) act_req = '0;
        end
        rd_req = '0;
    endtask

    task automatic test_wrdata();
        logic e;
        logic [NB-1:0] eg;
        do_reset();
        en = 1'b1;
        dfi_wren_lat = 4'd3;
        t_ccd_m1 = 4'd1;
        wr_req = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            if (k == 1) wr_req = '0;
            settle();
            e = (k == 4 || k == 5);
            vectors++; if (dfi_wrdata_en !== e) begin miscompares++; $display("FAIL wrdata_single[%0d]: got %b expected %b", k, dfi_wrdata_en, e); end
            tick();
        end
        wr_req = 4'b0001;
        for (int j = 0; j < 11; j++) begin
            if (j == 3) wr_req = '0;
            settle();
            e  = (j >= 4 && j <= 7);
            eg = (j == 0 || j == 2) ? 4'b0001 : 4'b0000;
            vectors++; if (dfi_wrdata_en !== e || wr_gnt !== eg) begin miscompares++; $display("FAIL wrdata_b2b[%0d]: got en=%b gnt=%b expected en=%b gnt=%b", j, dfi_wrdata_en, wr_gnt, e, eg); end
            tick();
        end
    endtask

    task automatic test_ref();
        do_reset();
        en = 1'b1;
        ca[0 +: CA] = 11'h7FF;
        id[0 +: IW] = 4'hA;
        ref_req = 4'b0111;
        rd_req = 4'b0001;
        settle();
        vectors++; if (ref_gnt !== 4'b0000 || rd_gnt !== 4'b0001) begin miscompares++; $display("FAIL ref_partial: got ref=%b rd=%b expected 0000/0001", ref_gnt, rd_gnt); end
        tick();
        rd_req = 4'b0010;
        ref_req = 4'b1111;
        vectors++; if ({dfi_ras_n, dfi_cas_n, dfi_we_n} !== 3'b101 || dfi_ba !== 3'd0 || dfi_addr !== 14'h3FF || cas_id !== 4'hA) begin miscompares++; $display("FAIL rd_cmd: got rcw=%b ba=%0d addr=%h id=%h expected 101/0/3ff/a", {dfi_ras_n, dfi_cas_n, dfi_we_n}, dfi_ba, dfi_addr, cas_id); end
        settle();
        vectors++; if (ref_gnt !== 4'b1111 || rd_gnt !== 4'b0000) begin miscompares++; $display("FAIL ref_full: got ref=%b rd=%b expected 1111/0000", ref_gnt, rd_gnt); end
        tick();
        ref_req = '0;
        rd_req = '0;
        vectors++; if (dfi_cs_n !== '0 || {dfi_ras_n, dfi_cas_n, dfi_we_n} !== 3'b001 || dfi_ba !== '0 || dfi_addr !== '0) begin miscompares++; $display("FAIL ref_cmd: got cs_n=%b rcw=%b ba=%0d addr=%h expected 0/001/0/0", dfi_cs_n, {dfi_ras_n, dfi_cas_n, dfi_we_n}, dfi_ba, dfi_addr); end
    endtask

    task automatic test_rst_window();
        do_reset();
        en = 1'b1;
        dfi_rden_lat = 4'd6;
        id[0 +: IW] = 4'h5;
        rd_req = 4'b0001;
        settle();
        tick();
        rd_req = '0;
        vectors++; if (dfi_cs_n !== '0 || cas_id !== 4'h5) begin miscompares++; $display("FAIL rstw_pre: got cs_n=%b id=%h expected 0/5", dfi_cs_n, cas_id); end
        rst = 1'b1;
        model_reset();
        #1;
        vectors++; if (dfi_cs_n !== '1 || {dfi_ras_n, dfi_cas_n, dfi_we_n} !== 3'b111 || dfi_cke !== 1'b0 || cas_id !== '0 || dfi_rddata_en !== 1'b0) begin miscompares++; $display("FAIL rstw_async: got cs_n=%b rcw=%b cke=%b id=%h rden=%b expected 1/111/0/0/0", dfi_cs_n, {dfi_ras_n, dfi_cas_n, dfi_we_n}, dfi_cke, cas_id, dfi_rddata_en); end
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            settle();
            vectors++; if (dfi_rddata_en !== 1'b0) begin miscompares++; $display("FAIL rstw_after[%0d]: got %b expected 0", k, dfi_rddata_en); end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        t_rrd_m1 = TW'($urandom_range(0, 3));
        t_ccd_m1 = TW'($urandom_range(0, 3));
        t_wtr_m1 = TW'($urandom_range(0, 4));
        t_rtw_m1 = TW'($urandom_range(0, 4));
        dfi_wren_lat = 4'($urandom_range(0, 7));
        dfi_rden_lat = 4'($urandom_range(0, 7));
        for (int n = 0; n < 400; n++) begin
            en = ($urandom_range(0, 9) != 0);
            act_req = NB'($urandom);
            rd_req = NB'($urandom) & NB'($urandom);
            wr_req = NB'($urandom) & ~rd_req;
            pre_req = NB'($urandom);
            ref_req = ($urandom_range(0, 7) == 0) ? '1 : NB'($urandom);
            for (int b = 0; b < NB; b++) begin
                ra[b*RA +: RA] = RA'($urandom);
                ca[b*CA +: CA] = CA'($urandom);
                id[b*IW +: IW] = IW'($urandom);
            end
            settle();
            vectors++; if ({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt} !== {m_act, m_rd, m_wr, m_pre, m_ref}) begin miscompares++; $display("FAIL rnd_gnt[%0d]: got a=%b r=%b w=%b p=%b f=%b expected a=%b r=%b w=%b p=%b f=%b", n, act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt, m_act, m_rd, m_wr, m_pre, m_ref); end
            vectors++; if (dfi_cs_n !== {DFI_CS_WIDTH{e_cs}} || {dfi_ras_n, dfi_cas_n, dfi_we_n} !== e_rcw || dfi_cke !== e_cke) begin miscompares++; $display("FAIL rnd_cmd[%0d]: got cs_n=%b rcw=%b cke=%b expected %b/%b/%b", n, dfi_cs_n, {dfi_ras_n, dfi_cas_n, dfi_we_n}, dfi_cke, e_cs, e_rcw, e_cke); end
            if (!e_cs) begin
                vectors++; if (dfi_ba !== DFI_BA_WIDTH'(e_ba) || dfi_addr !== DFI_ADDR_WIDTH'(e_addr)) begin miscompares++; $display("FAIL rnd_addr[%0d]: got ba=%0d addr=%h expected %0d/%h", n, dfi_ba, dfi_addr, e_ba, e_addr); end
            end
            vectors++; if (cas_id !== IW'(e_id)) begin miscompares++; $display("FAIL rnd_id[%0d]: got %h expected %h", n, cas_id, e_id); end
            vectors++; if (dfi_wrdata_en !== exp_wr[cyc] || dfi_rddata_en !== exp_rd[cyc]) begin miscompares++; $display("FAIL rnd_en[%0d]: got wr=%b rd=%b expected wr=%b rd=%b", n, dfi_wrdata_en, dfi_rddata_en, exp_wr[cyc], exp_rd[cyc]); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_act();
        test_rrd();
        test_wtr();
        test_wrdata();
        test_ref();
        test_rst_window();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dram_cmd_sched.md
# dram_cmd_sched

Rank-level DDR2 command scheduler between the per-bank controllers and the DFI control/data-enable ports. Arbitrates NUM_BANKS bank request sets (ACT/RD/WR/PRE/REF), enforces the inter-bank timing tRRD, tCCD, tWTR and tRTW, and issues at most one DRAM command per cycle on DFI. Also generates the dfi_wrdata_en and dfi_rddata_en windows from the programmed DFI latencies.

## Interface
- NUM_BANKS, 4: number of bank controllers/request sets.
- BURST_CYCLES, 2: DFI cycles per burst (wrdata_en/rddata_en width per CAS).
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  scheduler enable; 0 blocks all grants.
- act_req, rd_req, wr_req, pre_req, ref_req  in  NUM_BANKS each  per-bank requests, held until granted.
- ra  in  NUM_BANKS×DRAM_RA_WIDTH  row per bank; ca  in  NUM_BANKS×DRAM_CA_WIDTH  column per bank; id  in  NUM_BANKS×AXI_ID_WIDTH.
- act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt  out  NUM_BANKS each  one-cycle grants, combinational.
- t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1  in  T_*_WIDTH  timing minus one, quasi-static.
- dfi_wren_lat, dfi_rden_lat  in  4  CAS-to-enable latency in DFI cycles.
- dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_ba, dfi_addr, dfi_odt  out  DFI widths  registered command.
- dfi_wrdata_en, dfi_rddata_en  out  1  registered data enables.
- cas_id  out  AXI_ID_WIDTH  id of last granted RD/WR, registered with the command.

## Operation
- Grant classes, fixed priority: REF > CAS (RD/WR) > ACT > PRE. Highest class with an eligible request wins; one grant per cycle total.
- REF eligible only when ref_req is all-ones across banks; then ref_gnt = all-ones. Partial ref_req is ignored and does not block other classes.
- Within CAS, ACT and PRE: round-robin over banks. Separate pointer per class, reset to 0, moved to granted bank+1 (mod NUM_BANKS) on a grant in that class. RD and WR share the CAS pointer.
- Eligibility gates: ACT needs rrd_cnt==0. RD needs ccd_cnt==0 and wtr_cnt==0. WR needs ccd_cnt==0 and rtw_cnt==0. en==0 makes nothing eligible.
- Counters load on grant and count down to 0, saturating: ACT loads rrd_cnt←t_rrd_m1. RD/WR load ccd_cnt←t_ccd_m1. WR loads wtr_cnt←t_wtr_m1. RD loads rtw_cnt←t_rtw_m1.
- A bank's blocked CAS never blocks another bank's ACT/PRE in the same cycle. Arbitration is over eligible requests only.
- DFI encoding (ras_n/cas_n/we_n): ACT 011, RD 101, WR 100, PRE 010, REF 001, NOP 111.
- dfi_cs_n = 0 for a command, otherwise all-ones (deselect).
- Address: ACT addr=ra; RD/WR addr=ca with A10=0; PRE A10=0 (single bank); REF addr=0. dfi_ba = granted bank index (0 for REF).
- dfi_cke = registered en. dfi_odt tied 0.
- Data enables: two shift registers of depth 16+BURST_CYCLES. A WR command on DFI in cycle C drives dfi_wrdata_en high for cycles C+dfi_wren_lat … C+dfi_wren_lat+BURST_CYCLES−1 (a latency of 0 means the window starts in C). Same for RD/dfi_rddata_en. Overlapping windows OR together.

## Timing
- Reset: dfi_cke=0, dfi_cs_n=all-ones, ras/cas/we_n=1, ba/addr=0, odt=0, both data enables 0, cas_id=0, all counters and pointers 0, shift registers cleared.
- Grant in cycle T; command appears on DFI at T+1. Same-class spacing = t_x_m1+1 cycles between grant cycles.
- Reset mid-window cancels pending data enables immediately.
- en falling drops grants in the same cycle. Counters keep decrementing.

## Structure
- Shared package dram_sched_pkg: command enum (CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF), the ras/cas/we encoding constant function, and an A10 bit-index constant.
- Sub-module rr_arbiter (parameter N; req, ptr, gnt one-hot), instantiated three times: CAS, ACT, PRE.

## Test plan
- Reset, en=1, bank 2 ACT ra=0x1A5 -> act_gnt[2] in T. DFI at T+1: cs_n=0, ras/cas/we=011, ba=2, addr=0x1A5. dfi_cke=1.
- t_rrd_m1=2, ACT held on banks 0–3 -> grants at T, T+3, T+6, T+9 in order 0,1,2,3.
- WR bank 1 then RD bank 1, t_wtr_m1=5, t_ccd_m1=1 -> RD granted 6 cycles after WR. A concurrent ACT on bank 3 is granted in between.
- dfi_wren_lat=3, BURST_CYCLES=2, WR at DFI cycle C -> dfi_wrdata_en high exactly at C+3 and C+4. Back-to-back WRs 2 apart -> 4 contiguous cycles high.
- ref_req=0b0111 then 0b1111 -> no REF at 0b0111. At 0b1111, ref_gnt=0b1111, and REF wins over a simultaneous rd_req.
- Assert rst during a pending rddata_en window -> all outputs return to reset values asynchronously, and no enable pulse appears after release.
